// File: rtl/dmem_arbiter.sv
// Two-port (core / debug-DMA) arbiter in front of a single-ported data memory.
// Define DMEM_ARB_RR_EN for round-robin priority; otherwise port 0 always wins.
module dmem_arbiter #(
    parameter int MEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rsp_valid,
    output logic        p0_rsp_err,
    output logic [31:0] p0_rdata,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rsp_valid,
    output logic        p1_rsp_err,
    output logic [31:0] p1_rdata,

    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

    logic        gnt0;
    logic        gnt1;
    logic        sel_we;
    logic        in_range;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [31:0] rsp_data;

    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [1:0]       rsp_err_q,   rsp_err_d;
    logic [1:0][31:0] rdata_q,     rdata_d;

`ifdef DMEM_ARB_RR_EN
    logic ptr_q, ptr_d;  // 1: port 1 wins the next contended cycle
`endif

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
`ifdef DMEM_ARB_RR_EN
        gnt1 = p1_req && (!p0_req || ptr_q);
`else
        gnt1 = p1_req && !p0_req;
`endif
        gnt0 = p0_req && !gnt1;
        if (!rst_n) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end

        sel_we    = 1'b0;
        sel_addr  = 32'h0;
        sel_wdata = 32'h0;
        if (gnt1) begin
            sel_we    = p1_we;
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
        end else if (gnt0) begin
            sel_we    = p0_we;
            sel_addr  = p0_addr;
            sel_wdata = p0_wdata;
        end

        in_range = {2'b00, sel_addr[31:2]} < DEPTH_W;
        // Writes and out-of-range accesses return zero data.
        rsp_data = (sel_we || !in_range) ? 32'h0 : mem_rd;
    end

    always_comb begin
        rsp_valid_d = {gnt1, gnt0};
        rsp_err_d   = rsp_err_q;
        rdata_d     = rdata_q;
        if (gnt0) begin
            rsp_err_d[0] = !in_range;
            rdata_d[0]   = rsp_data;
        end
        if (gnt1) begin
            rsp_err_d[1] = !in_range;
            rdata_d[1]   = rsp_data;
        end
`ifdef DMEM_ARB_RR_EN
        ptr_d = ptr_q;
        if (gnt0) begin
            ptr_d = 1'b1;
        end else if (gnt1) begin
            ptr_d = 1'b0;
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            rdata_q     <= '0;
`ifdef DMEM_ARB_RR_EN
            ptr_q       <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rdata_q     <= rdata_d;
`ifdef DMEM_ARB_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign p0_gnt       = gnt0;
    assign p1_gnt       = gnt1;
    assign p0_rsp_valid = rsp_valid_q[0];
    assign p1_rsp_valid = rsp_valid_q[1];
    assign p0_rsp_err   = rsp_err_q[0];
    assign p1_rsp_err   = rsp_err_q[1];
    assign p0_rdata     = rdata_q[0];
    assign p1_rdata     = rdata_q[1];

    assign mem_we = sel_we && in_range;
    assign mem_a  = sel_addr;
    assign mem_wd = sel_wdata;

endmodule
